// File: rtl/hsv_pixel_sched_if.sv
// hsv_pixel_sched_if: camera, converter and result-stream signals of hsv_pixel_sched (HSV_SCHED_STATS_EN adds drop_cnt/conv_cnt)
interface hsv_pixel_sched_if #(parameter int IDX_W = 19);
    logic             frame_start;
    logic             pix_valid;
    logic [23:0]      pix_rgb;
    logic             cvt_enable;
    logic [23:0]      cvt_rgb;
    logic [23:0]      cvt_hsv;
    logic             cvt_done;
    logic             hsv_valid;
    logic             hsv_ready;
    logic [23:0]      hsv_data;
    logic [IDX_W-1:0] hsv_idx;
    logic             overflow_err;
    logic             timeout_err;
    logic             clear_err;
`ifdef HSV_SCHED_STATS_EN
    logic [15:0]      drop_cnt;
    logic [15:0]      conv_cnt;
`endif
    modport master (
        input  frame_start, pix_valid, pix_rgb, cvt_hsv, cvt_done, hsv_ready, clear_err,
        output cvt_enable, cvt_rgb, hsv_valid, hsv_data, hsv_idx, overflow_err, timeout_err
`ifdef HSV_SCHED_STATS_EN
        , drop_cnt, conv_cnt
`endif
    );
    modport slave (
        output frame_start, pix_valid, pix_rgb, cvt_hsv, cvt_done, hsv_ready, clear_err,
        input  cvt_enable, cvt_rgb, hsv_valid, hsv_data, hsv_idx, overflow_err, timeout_err
`ifdef HSV_SCHED_STATS_EN
        , drop_cnt, conv_cnt
`endif
    );
endinterface

// File: rtl/hsv_pixel_sched.sv
// hsv_pixel_sched: FIFO-buffered scheduler feeding rgb2hsv_clk one pixel at a time (HSV_SCHED_STATS_EN adds drop/conversion counters)
module hsv_pixel_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 19,
    parameter int TIMEOUT    = 63
) (
    input logic pclk,
    input logic rst,
    hsv_pixel_sched_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
    state_t           state;
    logic [IDX_W+23:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [IDX_W-1:0] idx_cnt, tag, cur_idx;
    logic [WW-1:0]    wait_cnt;
    logic             done_q, empty, full, pop, push, drop, rise, tmo, xfer;
    // Handshake decisions; a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        empty = count == '0;
        full  = count == (AW+1)'(FIFO_DEPTH);
        pop   = state == IDLE && !empty && !bus.cvt_done;
        push  = bus.pix_valid && (!full || pop);
        drop  = bus.pix_valid && full && !pop;
        rise  = state == WAIT && bus.cvt_done && !done_q;
        tmo   = state == WAIT && !rise && wait_cnt == WW'(TIMEOUT - 1);
        xfer  = state == OUT && bus.hsv_ready;
        tag   = bus.frame_start ? '0 : idx_cnt;
    end
    // Per-frame index: every strobed pixel, dropped or not, consumes one index
    always_ff @(posedge pclk) begin
        if (rst)
            idx_cnt <= '0;
        else if (bus.pix_valid)
            idx_cnt <= tag + 1'b1;
        else if (bus.frame_start)
            idx_cnt <= '0;
    end
    // FIFO storage, no reset needed since occupancy is tracked by count
    always_ff @(posedge pclk) begin
        if (push)
            mem[wr_ptr] <= {tag, bus.pix_rgb};
    end
    // FIFO pointers and occupancy
    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Issue/wait/output sequencer with registered converter and result outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cvt_enable <= 1'b0;
            bus.cvt_rgb   <= '0;
            bus.hsv_valid <= 1'b0;
            bus.hsv_data  <= '0;
            bus.hsv_idx   <= '0;
            cur_idx       <= '0;
            wait_cnt      <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= bus.cvt_done;
            case (state)
                IDLE: if (pop) begin
                    bus.cvt_enable <= 1'b1;
                    bus.cvt_rgb    <= mem[rd_ptr][23:0];
                    cur_idx        <= mem[rd_ptr][IDX_W+23:24];
                    state          <= ISSUE;
                end
                ISSUE: begin
                    bus.cvt_enable <= 1'b0;
                    wait_cnt       <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (rise) begin
                        bus.hsv_data  <= bus.cvt_hsv;
                        bus.hsv_idx   <= cur_idx;
                        bus.hsv_valid <= 1'b1;
                        state         <= OUT;
                    end else if (tmo)
                        state <= IDLE;
                end
                OUT: if (bus.hsv_ready) begin
                    bus.hsv_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
    // Sticky errors; a new event beats a simultaneous clear
    always_ff @(posedge pclk) begin
        if (rst) begin
            bus.overflow_err <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.overflow_err <= drop || (bus.overflow_err && !bus.clear_err);
            bus.timeout_err  <= tmo || (bus.timeout_err && !bus.clear_err);
        end
    end
`ifdef HSV_SCHED_STATS_EN
    // Frame statistics; an event on the frame_start cycle counts toward the new frame
    always_ff @(posedge pclk) begin
        if (rst) begin
            bus.drop_cnt <= '0;
            bus.conv_cnt <= '0;
        end else if (bus.frame_start) begin
            bus.drop_cnt <= 16'(drop);
            bus.conv_cnt <= 16'(xfer);
        end else begin
            bus.drop_cnt <= bus.drop_cnt + 16'(drop && bus.drop_cnt != 16'hFFFF);
            bus.conv_cnt <= bus.conv_cnt + 16'(xfer);
        end
    end
`endif
endmodule
